// File: rtl/watch_pkg.sv
// ---------------------------------------------------------------
// watch_pkg: shared stopwatch mode encodings and default timing constants.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package watch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    SET   = 2'b11
  } mode_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int TICK_DIV_DEF        = 100;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------
// btn_debounce: two-flop synchroniser, level debouncer and rising-edge press pulse.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module btn_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync_meta;
  logic       sync;
  logic [7:0] cnt;
  logic       db;
  logic       db_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      cnt       <= 8'd0;
      db        <= 1'b0;
      db_prev   <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync      <= sync_meta;
      db_prev   <= db;
      // The counter only runs while the synchronised level disagrees with db.
      if (sync == db) begin
        cnt <= 8'd0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync;
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign press = db & ~db_prev;

endmodule

`default_nettype wire

// File: rtl/watch_ctrl_fsm.sv
// ---------------------------------------------------------------
// watch_ctrl_fsm: button front-end, IDLE/RUN/PAUSE/SET mode machine and count tick.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module watch_ctrl_fsm
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TICK_DIV        = TICK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_set,
  output logic       run,
  output logic       stop,
  output logic       clr,
  output logic       set_load,
  output logic       tick,
  output logic [1:0] state
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic        press_start;
  logic        press_clear;
  logic        press_set;
  mode_t       mode;
  logic [15:0] prescaler;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (press_start)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (press_clear)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_set),
    .press (press_set)
  );

  // Each branch tests presses in clear > start > set order, so the first legal one wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode      <= IDLE;
      clr       <= 1'b0;
      prescaler <= 16'd0;
    end else begin
      clr <= 1'b0;
      case (mode)
        IDLE: begin
          prescaler <= 16'd0;
          if (press_clear) begin
            clr <= 1'b1;
          end else if (press_start) begin
            mode <= RUN;
          end else if (press_set) begin
            mode <= SET;
          end
        end
        RUN: begin
          prescaler <= (prescaler == TICK_LAST) ? 16'd0 : prescaler + 16'd1;
          if (press_start) begin
            mode <= PAUSE;
          end
        end
        PAUSE: begin
          if (press_clear) begin
            mode      <= IDLE;
            clr       <= 1'b1;
            prescaler <= 16'd0;
          end else if (press_start) begin
            mode <= RUN;
          end
        end
        SET: begin
          prescaler <= 16'd0;
          if (press_set) begin
            mode <= IDLE;
          end
        end
        default: begin
          mode      <= IDLE;
          prescaler <= 16'd0;
        end
      endcase
    end
  end

  assign state    = mode;
  assign run      = (mode == RUN);
  assign stop     = (mode == PAUSE);
  assign set_load = (mode == SET);
  assign tick     = (mode == RUN) && (prescaler == TICK_LAST);

endmodule

`default_nettype wire

// File: tb/tb_watch_ctrl_fsm.sv
// ---------------------------------------------------------------
// tb_watch_ctrl_fsm: scoreboard bench for watch_ctrl_fsm (DEBOUNCE_CYCLES=4, TICK_DIV=5).
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_watch_ctrl_fsm;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_SET   = 2'b11;

  // Selectors: 0 all outputs, 1 state, 2 run, 3 stop, 4 clr, 5 set_load, 6 tick
  typedef struct {
    int         cyc;
    int         sel;
    logic [6:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_set;
  logic       run;
  logic       stop;
  logic       clr;
  logic       set_load;
  logic       tick;
  logic [1:0] state;

  sb_t sb[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  watch_ctrl_fsm #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .btn_set   (btn_set),
    .run       (run),
    .stop      (stop),
    .clr       (clr),
    .set_load  (set_load),
    .tick      (tick),
    .state     (state)
  );

  function automatic string sel_name(input int sel);
    case (sel)
      0:       return "outputs";
      1:       return "state";
      2:       return "run";
      3:       return "stop";
      4:       return "clr";
      5:       return "set_load";
      default: return "tick";
    endcase
  endfunction

  function automatic logic [6:0] observe(input int sel);
    case (sel)
      0:       return {state, run, stop, clr, set_load, tick};
      1:       return {5'd0, state};
      2:       return {6'd0, run};
      3:       return {6'd0, stop};
      4:       return {6'd0, clr};
      5:       return {6'd0, set_load};
      default: return {6'd0, tick};
    endcase
  endfunction

  function automatic logic [6:0] vec(input logic [1:0] st, input logic r, input logic s,
                                     input logic c, input logic sl, input logic t);
    return {st, r, s, c, sl, t};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_at(input int c, input int sel, input logic [6:0] v);
    sb_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Tick is due whenever (cycle - rb) mod 5 == 4, rb being the effective RUN start.
  task automatic exp_ticks(input int from, input int to, input int rb);
    for (int c = from; c <= to; c++) begin
      expect_at(c, 6, ((c - rb) % 5 == 4) ? 7'd1 : 7'd0);
    end
  endtask

  task automatic step();
    int i;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        check_val(sel_name(sb[i].sel), 16'(observe(sb[i].sel)), 16'(sb[i].exp));
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic drain();
    int lim;
    lim = 200;
    while (sb.size() > 0 && lim > 0) begin
      step();
      lim--;
    end
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, r, p, p2, rb2;

    reset     = 1'b1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    btn_set   = 1'b0;

    // Reset, then 20 quiet cycles with every output low
    for (int k = 1; k <= 3; k++) expect_at(k, 0, 7'd0);
    idle_steps(3);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) expect_at(cyc + k, 0, 7'd0);
    drain();

    // Start held: RUN at E0+6, tick every 5 cycles, no repeat transitions
    btn_start = 1'b1;
    e0 = cyc + 1;
    r  = e0 + 6;
    expect_at(e0 + 5, 1, {5'd0, S_IDLE});
    expect_at(r, 0, vec(S_RUN, 1, 0, 0, 0, 0));
    exp_ticks(r + 1, r + 20, r);
    expect_at(e0 + 25, 1, {5'd0, S_RUN});
    drain();

    btn_start = 1'b0;
    exp_ticks(cyc + 1, cyc + 8, r);
    drain();
    while ((cyc + 6 - r) % 5 != 2) begin
      exp_ticks(cyc + 1, cyc + 1, r);
      step();
    end

    // Pause while the prescaler sits at 2
    btn_start = 1'b1;
    e0 = cyc + 1;
    p  = e0 + 6;
    exp_ticks(cyc + 1, p - 1, r);
    expect_at(p, 0, vec(S_PAUSE, 0, 1, 0, 0, 0));
    drain();
    btn_start = 1'b0;
    for (int k = 1; k <= 8; k++) expect_at(cyc + k, 0, vec(S_PAUSE, 0, 1, 0, 0, 0));
    drain();

    // Resume: partial period continues, first tick in the second RUN cycle
    btn_start = 1'b1;
    e0 = cyc + 1;
    p2 = e0 + 6;
    expect_at(p2 - 1, 1, {5'd0, S_PAUSE});
    expect_at(p2, 0, vec(S_RUN, 1, 0, 0, 0, 0));
    rb2 = p2 - 3;
    exp_ticks(p2 + 1, p2 + 6, rb2);
    drain();
    btn_start = 1'b0;
    exp_ticks(cyc + 1, cyc + 8, rb2);
    drain();
    btn_start = 1'b1;
    e0 = cyc + 1;
    exp_ticks(cyc + 1, e0 + 5, rb2);
    expect_at(e0 + 6, 0, vec(S_PAUSE, 0, 1, 0, 0, 0));
    drain();
    btn_start = 1'b0;
    idle_steps(8);

    // Short clear glitch in PAUSE is rejected
    for (int k = 1; k <= 12; k++) expect_at(cyc + k, 0, vec(S_PAUSE, 0, 1, 0, 0, 0));
    btn_clear = 1'b1;
    idle_steps(3);
    btn_clear = 1'b0;
    drain();

    // Long clear in PAUSE: IDLE with a single clr pulse
    btn_clear = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 5, 0, vec(S_PAUSE, 0, 1, 0, 0, 0));
    expect_at(e0 + 6, 0, vec(S_IDLE, 0, 0, 1, 0, 0));
    expect_at(e0 + 7, 0, vec(S_IDLE, 0, 0, 0, 0, 0));
    idle_steps(10);
    btn_clear = 1'b0;
    drain();
    for (int k = 1; k <= 8; k++) expect_at(cyc + k, 0, 7'd0);
    drain();

    // Clear and start together in RUN: start wins, no clr
    btn_start = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 6, 1, {5'd0, S_RUN});
    drain();
    btn_start = 1'b0;
    idle_steps(8);
    btn_start = 1'b1;
    btn_clear = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 6, 0, vec(S_PAUSE, 0, 1, 0, 0, 0));
    expect_at(e0 + 7, 4, 7'd0);
    drain();
    btn_start = 1'b0;
    btn_clear = 1'b0;
    idle_steps(8);
    btn_clear = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 6, 0, vec(S_IDLE, 0, 0, 1, 0, 0));
    drain();
    btn_clear = 1'b0;
    idle_steps(8);

    // SET mode entry, ignored start, exit
    btn_set = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 5, 1, {5'd0, S_IDLE});
    expect_at(e0 + 6, 0, vec(S_SET, 0, 0, 0, 1, 0));
    drain();
    btn_set = 1'b0;
    idle_steps(8);
    btn_start = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 6, 0, vec(S_SET, 0, 0, 0, 1, 0));
    expect_at(e0 + 7, 0, vec(S_SET, 0, 0, 0, 1, 0));
    drain();
    btn_start = 1'b0;
    idle_steps(8);
    btn_set = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 6, 0, 7'd0);
    drain();
    btn_set = 1'b0;
    idle_steps(8);
    btn_set = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 6, 0, vec(S_SET, 0, 0, 0, 1, 0));
    drain();
    btn_set = 1'b0;
    idle_steps(8);

    // Reset mid-SET: IDLE on the next edge, no clr
    reset = 1'b1;
    expect_at(cyc + 1, 0, 7'd0);
    expect_at(cyc + 2, 0, 7'd0);
    idle_steps(2);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) expect_at(cyc + k, 0, 7'd0);
    drain();

    check_val("sb_drain", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/watch_ctrl_fsm.md
Name: watch_ctrl_fsm

Overview:
Front-end control stage for the stopwatch digit chain. It synchronises and debounces three push-buttons, runs the IDLE/RUN/PAUSE/SET mode machine, and drives the digit counters' start_resume, stop, reset and set inputs. It also generates the single-cycle count tick that advances the least-significant digit counter. It sits directly upstream of the mod-N digit counters.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised button level must differ from the debounced level before it is accepted; range 2..255.
TICK_DIV, 100, clk cycles per count tick; range 2..65535.

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-high reset.
btn_start  in  1  raw start/pause button, asynchronous.
btn_clear  in  1  raw clear button, asynchronous.
btn_set  in  1  raw set-mode toggle button, asynchronous.
run  out  1  to counter start_resume; high while in RUN.
stop  out  1  to counter stop; high while in PAUSE.
clr  out  1  to counter reset; one-cycle pulse.
set_load  out  1  to counter set; high while in SET.
tick  out  1  one-cycle count-enable pulse, RUN only.
state  out  2  current mode: IDLE=00, RUN=01, PAUSE=10, SET=11.

Behaviour:
- Reset: state=IDLE. run, stop, clr, set_load and tick are 0. Prescaler=0. All synchroniser flops, debounce counters, debounced levels and previous-level flops are 0. Reset has priority over every other input. A reset asserted mid-RUN returns the block to IDLE on the next edge and produces no clr pulse.
- Input path, per button:
  - Two-flop synchroniser feeds sync.
  - Debounce counter cnt: on each edge, if sync==db then cnt<=0. Otherwise, if cnt==DEBOUNCE_CYCLES-1 then db<=sync and cnt<=0, else cnt<=cnt+1.
  - press = db & ~db_prev (combinational). db_prev<=db every edge.
  - Only rising edges generate presses. A release generates nothing.
- Latency: take edge E0 as the first edge that samples the new raw level. db rises after edge E0+1+DEBOUNCE_CYCLES. press is high for exactly one cycle after that edge. state updates at edge E0+2+DEBOUNCE_CYCLES.
- Glitch rejection: any raw pulse or bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no press.
- Press priority within one cycle: clear > start > set. Only the highest-priority press that is legal in the current state acts. All other presses that cycle are discarded.
- Transitions (registered):
  - IDLE: start -> RUN. clear -> IDLE, with clr pulsed next cycle. set -> SET.
  - RUN: start -> PAUSE. clear and set are ignored; a start in the same cycle still acts.
  - PAUSE: start -> RUN. clear -> IDLE, with clr pulsed. set is ignored.
  - SET: set -> IDLE. start and clear are ignored.
- Outputs are decoded from registered state, except as noted:
  - run = (state==RUN). stop = (state==PAUSE). set_load = (state==SET).
  - clr is a registered pulse, high for exactly the one cycle following the accepted clear press.
- Prescaler: 16-bit.
  - In RUN it increments every cycle and wraps from TICK_DIV-1 to 0.
  - In PAUSE it holds its value, so resume continues the partial period.
  - In IDLE or SET it is forced to 0.
  - tick = (state==RUN) & (prescaler==TICK_DIV-1), combinational, high one cycle per period.
  - On entry to RUN from IDLE the first tick occurs in the TICK_DIV-th cycle spent in RUN.
- Buttons held continuously produce exactly one press. No auto-repeat.

Decomposition:
- Shared package watch_pkg holds the state encodings IDLE/RUN/PAUSE/SET (2-bit) and the default DEBOUNCE_CYCLES and TICK_DIV constants for reuse by the display stage.
- One sub-module, btn_debounce (synchroniser, debounce counter, press output, DEBOUNCE_CYCLES parameter), is instantiated three times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and TICK_DIV=5.
- Reset then idle for 20 cycles -> state=00; run, stop, clr, set_load and tick stay 0 throughout.
- btn_start raised at E0 and held -> state=01 after edge E0+6. run=1. tick first high in the 5th RUN cycle, then every 5 cycles. Holding the button produces no further transitions.
- From RUN with prescaler=2, start press -> PAUSE, stop=1, tick=0. A second start press -> RUN, and the first tick arrives 2 cycles after re-entry.
- btn_clear pulse 3 cycles wide in PAUSE -> no state change. Pulse 10 cycles wide -> state=00, and clr high for exactly one cycle.
- Presses of btn_clear and btn_start landing in the same cycle while in RUN -> state=10 (start acts, clear ignored).
- In IDLE, set press -> state=11 and set_load=1. A start press in SET is ignored. A set press -> state=00 and set_load=0. Asserting reset mid-SET -> state=00 next edge, with no clr pulse.
